// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// default baud derivation for the 25 MHz core clock.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int CLK_HZ           = 25_000_000;
    localparam int BAUD             = 9600;
    localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    function automatic logic parity_bit(input logic [7:0] b, input int mode);
        case (mode)
            PAR_EVEN: return ^b;
            PAR_ODD:  return ~^b;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy; dout shows the head entry
// combinationally, full/empty come straight from the level register.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queued bytes leave as back-to-back 8N1/8E1/8O1/8N2
// frames; first start bit one cycle after a push into an idle, empty queue.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_par;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic        w_bit_end;
    logic        w_last_data;
    logic        w_last_stop;

    assign w_push      = in_valid && !w_full;
    assign w_bit_end   = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_last_data = (r_bit == 3'd7);
    assign w_last_stop = (r_bit == 3'(STOP_BITS - 1));

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            if (w_pop)
                r_par <= parity_bit(w_head, PARITY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_end && w_last_data)
                          w_state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end && w_last_stop)
                          w_state_nxt = w_empty ? S_IDLE : S_START;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Every entry into START is a pop; tx is computed from the next state so the line is registered.
    always_comb begin
        w_pop       = (w_state_nxt == S_START) && (r_state == S_IDLE || r_state == S_STOP);
        w_baud_nxt  = (r_state == S_IDLE || w_pop || w_bit_end) ? '0 : r_baud + BW'(1);
        w_bit_nxt   = (w_state_nxt != r_state) ? 3'd0 : (w_bit_end ? r_bit + 3'd1 : r_bit);
        w_shift_nxt = r_shift;
        if (w_pop)
            w_shift_nxt = w_head;
        else if (r_state == S_DATA && w_bit_end)
            w_shift_nxt = {1'b0, r_shift[7:1]};
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = r_par;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign in_ready = !w_full;
    assign busy     = (r_state != S_IDLE) || !w_empty;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter that pairs with the existing UART receiver. It accepts bytes over a valid/ready handshake into an internal byte FIFO, then serializes them onto tx as 8N1/8E1/8O1/8N2 frames (LSB first).
- It lets upstream logic, such as a response generator, queue whole messages without polling per byte.
- Frames are sent back-to-back with no idle gap while data remains queued.

Parameters:
- CLKS_PER_BIT, 2604, clk cycles per serial bit (25 MHz / 9600 baud); must be ≥2.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, ≥2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- in_data  input  8  byte to enqueue.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !full.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. On assertion: tx=1, busy=0, fifo_level=0, in_ready=1, FIFO pointers cleared, FSM=IDLE, bit counter and baud counter cleared.
- Reset mid-frame: the frame is truncated, tx returns high immediately, and queued bytes are discarded.
- Handshake: a push occurs on any rising edge with in_valid && in_ready. in_ready is derived only from the registered count, with no combinational path from in_valid.
  - Push when full: impossible, since in_ready=0.
  - Pop when empty: never occurs.
  - Simultaneous push and pop: fifo_level is unchanged.
  - FIFO full and pop in the same cycle: in_ready stays 0 that cycle and rises the next cycle.
- FSM states:
  - IDLE, tx=1. If the FIFO is non-empty: pop the head into the shift register, load the parity bit, drive tx=0, go to START.
  - START, tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA, tx=shift[0] for 8 bits, each CLKS_PER_BIT cycles, shifting right after each bit; then PARITY if PARITY≠0, else STOP.
  - PARITY, tx=^byte (even) or ~^byte (odd), held CLKS_PER_BIT cycles.
  - STOP, tx=1 for STOP_BITS×CLKS_PER_BIT cycles. At the last cycle: if the FIFO is non-empty, pop and go directly to START (next cycle tx=0, no gap); else go to IDLE.
- Latency: a byte pushed into an empty FIFO while IDLE at edge N is popped at edge N+1, and tx falls after edge N+1.
- Frame length: (10 + (PARITY≠0) + (STOP_BITS−1)) × CLKS_PER_BIT cycles, exact and with no drift.
  - The baud counter counts 0..CLKS_PER_BIT−1.
  - The bit boundary is at count==CLKS_PER_BIT−1.
  - The counter restarts at 0 on every pop.
- Data capture: in_data is captured at push. Changes to in_data after a push do not affect the queued byte.
- busy: low only when FSM=IDLE and the FIFO is empty.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is 3 bits; FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- tx is registered (no glitches).

Decomposition:
- Package uart_pkg:
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - TX FSM state encoding IDLE/START/DATA/PARITY/STOP.
  - Default CLK_HZ / BAUD constants and the CLKS_PER_BIT derivation.
- Sub-module uart_byte_fifo: synchronous FIFO, parameter DEPTH, ports push/pop/din/dout/full/empty/level. The top contains the baud counter and serializer FSM only.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset: assert reset mid-sim with clk stopped -> tx=1, busy=0, in_ready=1, fifo_level=0 immediately.
- Single 0xA5, PARITY=0, STOP_BITS=1: push at edge N -> tx from edge N+1 is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy falls 40 cycles after tx falls.
- Parity: 0x07 with PARITY=1 -> parity bit 1; with PARITY=2 -> parity bit 0. 0x00 with PARITY=1 -> parity bit 0. Frame length is 44 cycles.
- Burst: hold in_valid=1 with bytes 0x01..0x0A, FIFO_DEPTH=8 -> 9 accepted before in_ready first drops. Each later acceptance coincides with a pop. All 10 frames are contiguous (stop bit directly followed by start bit), in order.
- STOP_BITS=2, two queued bytes -> tx high for exactly 8 cycles between frames; total 2×44 cycles.
- Reset during data bit 3 of 0xFF with 3 bytes queued -> tx=1 at once, fifo_level=0. After release, no start bit until a new push.
